// File: rtl/pio_poll_pkg.sv
// Shared types and constants for the PIO count poller: FSM states,
// slave read latency and the default poll period.
package pio_poll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_EMIT
  } poll_state_e;

  localparam int AVM_READ_LATENCY    = 1;
  localparam int POLL_PERIOD_DEFAULT = 1000;

endpackage

// File: rtl/poll_timer.sv
// Free-running poll period counter: a one-cycle tick every POLL_PERIOD
// enabled cycles, frozen while enable is low.
module poll_timer
  import pio_poll_pkg::*;
#(
  parameter int POLL_PERIOD = POLL_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] RELOAD = 16'(POLL_PERIOD - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick = enable && (cnt_q == 16'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = (cnt_q == 16'd0) ? RELOAD : cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pio_count_poller.sv
// Periodically reads a PIO count over Avalon-MM and emits a valid/ready
// event carrying new and previous values whenever the count changes.
module pio_count_poller
  import pio_poll_pkg::*;
#(
  parameter int POLL_PERIOD = POLL_PERIOD_DEFAULT,
  parameter int DATA_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_data,
  output logic [DATA_W-1:0] evt_prev,
  output logic              overrun,
  input  logic              overrun_clr
);

  logic              tick;
  poll_state_e       state_q;
  logic              avm_read_q;
  logic              evt_valid_q;
  logic              overrun_q;
  logic              first_q;
  logic [DATA_W-1:0] last_q;
  logic [DATA_W-1:0] evt_data_q;
  logic [DATA_W-1:0] evt_prev_q;
  logic [DATA_W-1:0] cur_d;
  logic              unused_readdata;

  poll_timer #(
    .POLL_PERIOD(POLL_PERIOD)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  // Only the count field matters; the slave's upper bits are don't-care.
  assign cur_d           = avm_readdata[DATA_W-1:0];
  assign unused_readdata = ^avm_readdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      avm_read_q  <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      evt_prev_q  <= '0;
      last_q      <= '0;
      first_q     <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      avm_read_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q    <= ST_READ;
            avm_read_q <= 1'b1;
          end
        end
        ST_READ: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          last_q  <= cur_d;
          first_q <= 1'b0;
          if (first_q || (cur_d != last_q)) begin
            state_q     <= ST_EMIT;
            evt_valid_q <= 1'b1;
            evt_data_q  <= cur_d;
            evt_prev_q  <= last_q;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (evt_ready) begin
            state_q     <= ST_IDLE;
            evt_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A tick swallowed while an event is still pending is a lost poll.
      if (tick && (state_q == ST_EMIT)) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign avm_address = 2'b00;
  assign avm_read    = avm_read_q;
  assign evt_valid   = evt_valid_q;
  assign evt_data    = evt_data_q;
  assign evt_prev    = evt_prev_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pio_count_poller.sv
// Randomized bench for pio_count_poller against a timestamp-based event model.
module tb_pio_count_poller;

  localparam int P  = 8;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          evt_ready;
  logic          overrun_clr;
  logic [31:0]   avm_readdata;
  logic [1:0]    avm_address;
  logic          avm_read;
  logic          evt_valid;
  logic [DW-1:0] evt_data;
  logic [DW-1:0] evt_prev;
  logic          overrun;

  pio_count_poller #(
    .POLL_PERIOD(P),
    .DATA_W     (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .avm_address (avm_address),
    .avm_read    (avm_read),
    .avm_readdata(avm_readdata),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_data    (evt_data),
    .evt_prev    (evt_prev),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: interval index since reset, enabled-interval count, cycle of the
  // in-flight read, and the pending event (if any).
  int          cyc;
  int          en_cnt;
  int          rd_cyc;
  bit          m_pend;
  logic [3:0]  m_data;
  logic [3:0]  m_prev;
  logic [3:0]  m_last;
  bit          m_first;
  bit          m_ovr;

  int          first_rd_cyc;
  bit          rd_seen;
  int          dut_rd;
  int          dut_hs;
  logic [3:0]  last_hs_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc     = 1;
    en_cnt  = 0;
    rd_cyc  = -100;
    m_pend  = 0;
    m_data  = '0;
    m_prev  = '0;
    m_last  = '0;
    m_first = 1;
    m_ovr   = 0;
    rd_seen = 0;
    dut_rd  = 0;
  endtask

  task automatic check_outputs();
    check_eq("avm_address", {30'd0, avm_address}, 32'd0);
    check_eq("avm_read", {31'd0, avm_read}, {31'd0, (cyc == rd_cyc)});
    check_eq("evt_valid", {31'd0, evt_valid}, {31'd0, m_pend});
    if (m_pend) begin
      check_eq("evt_data", {28'd0, evt_data}, {28'd0, m_data});
      check_eq("evt_prev", {28'd0, evt_prev}, {28'd0, m_prev});
    end
    check_eq("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    if (avm_read) begin
      dut_rd++;
      if (!rd_seen) begin
        rd_seen      = 1;
        first_rd_cyc = cyc;
      end
    end
  endtask

  // Advance the model across the coming rising edge using this interval's inputs.
  task automatic model_advance();
    bit         tk;
    bit         cap;
    bit         busy;
    logic [3:0] v;
    tk   = enable && (((en_cnt + 1) % P) == 0);
    if (enable) en_cnt++;
    cap  = (cyc == rd_cyc + 1);
    busy = (cyc == rd_cyc) || cap || m_pend;
    if (tk && m_pend) m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
    if (m_pend && evt_ready) m_pend = 0;
    if (cap) begin
      v = avm_readdata[3:0];
      if (m_first || (v != m_last)) begin
        m_pend = 1;
        m_data = v;
        m_prev = m_last;
      end
      m_last  = v;
      m_first = 0;
    end
    if (tk && !busy) rd_cyc = cyc + 1;
    cyc++;
  endtask

  task automatic step_body(input logic en, input logic rdy, input logic clr, input logic [31:0] rd);
    check_outputs();
    enable       = en;
    evt_ready    = rdy;
    overrun_clr  = clr;
    avm_readdata = rd;
    if (evt_valid && evt_ready) begin
      dut_hs++;
      last_hs_data = evt_data;
    end
    model_advance();
  endtask

  task automatic step(input logic en, input logic rdy, input logic clr, input logic [31:0] rd);
    @(negedge clk);
    step_body(en, rdy, clr, rd);
  endtask

  task automatic do_reset(input logic [31:0] rd);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check_eq("rst_avm_read", {31'd0, avm_read}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    check_eq("rst_evt_data", {28'd0, evt_data}, 32'd0);
    check_eq("rst_evt_prev", {28'd0, evt_prev}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step_body(1'b1, 1'b1, 1'b0, rd);
  endtask

  initial begin
    int         hs_before;
    int         waited;
    logic [3:0] sv;
    logic [3:0] tgt;

    reset        = 1'b1;
    enable       = 1'b0;
    evt_ready    = 1'b0;
    overrun_clr  = 1'b0;
    avm_readdata = '0;
    dut_hs       = 0;
    last_hs_data = '0;
    model_reset();

    // First event after reset, then a constant value over three more polls.
    do_reset({$urandom_range(0, 65535), 16'h0003} & 32'hFFFF_FFF3 | 32'h3);
    for (int i = 0; i < 4 * P + 1; i++) step(1'b1, 1'b1, 1'b0, {28'h0, 4'h3});
    check_eq("first_rd_cycle", first_rd_cyc, P + 1);
    check_eq("const_reads", dut_rd, 4);
    check_eq("const_events", dut_hs, 1);

    // Change to 5 with the consumer stalled, then clear while ticks keep landing.
    for (int i = 0; i < 3 * P; i++) step(1'b1, 1'b0, 1'b0, {28'h0, 4'h5});
    check_eq("stall_overrun", {31'd0, overrun}, 32'd1);
    for (int i = 0; i < 2 * P; i++) step(1'b1, 1'b0, 1'b1, {28'h0, 4'h5});
    hs_before = dut_hs;
    for (int i = 0; i < 2 * P; i++) step(1'b1, 1'b1, 1'b0, {28'h0, 4'h5});
    check_eq("stall_release_hs", dut_hs - hs_before, 1);
    check_eq("stall_release_data", {28'd0, last_hs_data}, 32'd5);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, {28'h0, 4'h5});
    check_eq("clr_alone", {31'd0, overrun}, 32'd0);

    // Upper readdata bits must be ignored.
    for (int i = 0; i < 2 * P + 4; i++) step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF7);
    check_eq("upper_ignored", {28'd0, last_hs_data}, 32'd7);

    // Randomized traffic.
    sv = 4'h7;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) sv = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 9) < 8), $urandom_range(0, 1), ($urandom_range(0, 9) == 0),
           {$urandom_range(0, 32'h0FFF_FFFF), sv});
    end

    // Reset while an event is pending; the same value must be re-emitted afterwards.
    tgt    = (m_last == 4'h9) ? 4'hA : 4'h9;
    waited = 0;
    while (!m_pend && waited < 4 * P) begin
      step(1'b1, 1'b0, 1'b0, {28'h0, tgt});
      waited++;
    end
    if (!m_pend) check_eq("emit_wait_timeout", waited, 0);
    else begin
      @(negedge clk);
      check_eq("pre_rst_valid", {31'd0, evt_valid}, 32'd1);
    end
    hs_before = dut_hs;
    do_reset({28'h0, tgt});
    for (int i = 0; i < 3 * P; i++) step(1'b1, 1'b1, 1'b0, {28'h0, tgt});
    check_eq("post_rst_events", dut_hs - hs_before, 1);
    check_eq("post_rst_data", {28'd0, last_hs_data}, {28'd0, tgt});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
